// File: rtl/zeroriscy_fetch_realigner.sv
// zeroriscy_fetch_realigner
// Buffers 32-bit fetched words and hands the decoder one PC-aligned
// instruction per handshake. The instruction is either a 16-bit compressed
// one or a 32-bit one that may straddle two buffered words. A flush drops
// everything buffered and restarts at a new, possibly halfword-aligned, PC.

module zeroriscy_fetch_realigner #(
   parameter int DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic [31:0] branch_addr_i,
   input  logic        in_valid_i,
   input  logic [31:0] in_rdata_i,
   output logic        in_ready_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_rdata_o,
   output logic [31:0] out_addr_o
);

   localparam int CW = $clog2(DEPTH + 1);

   // Word storage. Entry 0 is always the oldest word, which holds the
   // halfword that pc points to.
   logic [31:0]   words      [DEPTH];
   logic [31:0]   words_next [DEPTH];
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          offset;
   logic          offset_next;
   logic [31:0]   pc;
   logic [31:0]   pc_next;

   logic          is_compressed;
   logic          instr_valid;
   logic [31:0]   instr;
   logic          push;
   logic          pop;
   logic          free_word;
   int            wr_pos;

   // Pick the instruction at the current halfword offset out of the stored
   // words. A 32-bit instruction that starts in the upper half of w0 is only
   // complete once w1 has arrived.
   always_comb begin
      is_compressed = offset ? (words[0][17:16] != 2'b11)
                             : (words[0][1:0]   != 2'b11);
      instr_valid   = 1'b0;
      instr         = 32'h0;
      if (count != '0) begin
         if (!offset) begin
            instr_valid = 1'b1;
            instr       = is_compressed ? {16'h0, words[0][15:0]} : words[0];
         end else if (is_compressed) begin
            instr_valid = 1'b1;
            instr       = {16'h0, words[0][31:16]};
         end else if (count > CW'(1)) begin
            instr_valid = 1'b1;
            instr       = {words[1][15:0], words[0][31:16]};
         end
      end
   end

   assign in_ready_o  = (count < CW'(DEPTH));
   assign out_valid_o = instr_valid;
   assign out_rdata_o = instr;
   assign out_addr_o  = pc;

   assign push      = in_valid_i & in_ready_o & ~clear_i;
   assign pop       = instr_valid & out_ready_i & ~clear_i;
   // The oldest word is used up once its upper half has been consumed, which
   // happens for any instruction starting at offset 1 or a full 32-bit one
   // at offset 0.
   assign free_word = pop & (offset | ~is_compressed);

   // Next-state computation: flush wins outright; otherwise pop advances the
   // PC and may free w0 (shifting the FIFO down), and a push lands just past
   // the last valid entry after that shift.
   always_comb begin
      words_next  = words;
      count_next  = count;
      offset_next = offset;
      pc_next     = pc;
      wr_pos      = int'(count) - (free_word ? 1 : 0);
      if (clear_i) begin
         count_next  = '0;
         pc_next     = {branch_addr_i[31:1], 1'b0};
         offset_next = branch_addr_i[1];
      end else begin
         if (pop) begin
            pc_next     = pc + (is_compressed ? 32'd2 : 32'd4);
            offset_next = is_compressed ? ~offset : offset;
         end
         if (free_word) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               words_next[i] = words[i + 1];
            end
         end
         if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (i == wr_pos) begin
                  words_next[i] = in_rdata_i;
               end
            end
         end
         case ({push, free_word})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
         endcase
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            words[i] <= 32'h0;
         end
         count  <= '0;
         offset <= 1'b0;
         pc     <= 32'h0;
      end else begin
         words  <= words_next;
         count  <= count_next;
         offset <= offset_next;
         pc     <= pc_next;
      end
   end

endmodule

// File: tb/tb_zeroriscy_fetch_realigner.sv
// Directed testbench for zeroriscy_fetch_realigner (DEPTH=3).
// Expected values are hand-computed from the described realignment behaviour.

module tb_zeroriscy_fetch_realigner;

   logic        clk;
   logic        rst;
   logic        clear_i;
   logic [31:0] branch_addr_i;
   logic        in_valid_i;
   logic [31:0] in_rdata_i;
   logic        in_ready_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_rdata_o;
   logic [31:0] out_addr_o;

   int compared;
   int mismatched;

   zeroriscy_fetch_realigner #(.DEPTH(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (clear_i),
      .branch_addr_i (branch_addr_i),
      .in_valid_i    (in_valid_i),
      .in_rdata_i    (in_rdata_i),
      .in_ready_o    (in_ready_o),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_rdata_o   (out_rdata_o),
      .out_addr_o    (out_addr_o)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then return 1 ns after the rising edge.
   task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic rdy,
                                input logic clr, input logic [31:0] baddr);
      in_valid_i    = vld;
      in_rdata_i    = data;
      out_ready_i   = rdy;
      clear_i       = clr;
      branch_addr_i = baddr;
      @(posedge clk);
      #1;
   endtask

   // Check the full visible output set in one call.
   task automatic checkOut(input string tag, input logic vld, input logic [31:0] rdata,
                           input logic [31:0] addr);
      checkOutput({tag, ".valid"}, {31'h0, out_valid_o}, {31'h0, vld});
      checkOutput({tag, ".rdata"}, out_rdata_o, rdata);
      checkOutput({tag, ".addr"}, out_addr_o, addr);
   endtask

   initial begin
      compared      = 0;
      mismatched    = 0;
      rst           = 1'b1;
      clear_i       = 1'b0;
      branch_addr_i = 32'h0;
      in_valid_i    = 1'b0;
      in_rdata_i    = 32'h0;
      out_ready_i   = 1'b0;
      #12;
      rst = 1'b0;

      // Reset state
      checkOut("rst", 1'b0, 32'h0, 32'h0);
      checkOutput("rst.in_ready", {31'h0, in_ready_o}, 32'h1);

      // Aligned 32-bit stream
      applyStimulus(1'b1, 32'h00100093, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h00200113, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
      checkOut("al0", 1'b1, 32'h00100093, 32'h0);
      checkOutput("al0.count", 32'(dut.count), 32'd2);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOut("al1", 1'b1, 32'h00200113, 32'h4);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOut("al2", 1'b0, 32'h0, 32'h8);
      checkOutput("al2.count", 32'(dut.count), 32'd0);

      // Compressed pair in one word
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      applyStimulus(1'b1, 32'h00050001, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOut("cp0", 1'b1, 32'h00000001, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOut("cp1", 1'b1, 32'h00000005, 32'h2);
      checkOutput("cp1.count", 32'(dut.count), 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOut("cp2", 1'b0, 32'h0, 32'h4);
      checkOutput("cp2.count", 32'(dut.count), 32'd0);
      checkOutput("cp2.offset", 32'(dut.offset), 32'd0);

      // Straddling 32-bit instruction after a flush to a halfword address
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000103);
      checkOut("st0", 1'b0, 32'h0, 32'h102);
      applyStimulus(1'b1, 32'h0093ABCD, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOut("st1", 1'b0, 32'h0, 32'h102);
      applyStimulus(1'b1, 32'h12340010, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOut("st2", 1'b1, 32'h00100093, 32'h102);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      out_ready_i = 1'b0;
      checkOut("st3", 1'b1, 32'h00001234, 32'h106);
      checkOutput("st3.offset", 32'(dut.offset), 32'd1);
      checkOutput("st3.count", 32'(dut.count), 32'd1);

      // Fill to full, then flush with a word arriving in the same cycle
      applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("full.in_ready", {31'h0, in_ready_o}, 32'h0);
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00000080);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOut("fl0", 1'b0, 32'h0, 32'h80);
      checkOutput("fl0.count", 32'(dut.count), 32'd0);
      checkOutput("fl0.in_ready", {31'h0, in_ready_o}, 32'h1);

      // Backpressure: fill, then pop while a word waits on the input
      applyStimulus(1'b1, 32'h00000513, 1'b0, 1'b0, 32'h0);
      checkOut("bp0", 1'b1, 32'h00000513, 32'h80);
      applyStimulus(1'b1, 32'h00600313, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h00700393, 1'b0, 1'b0, 32'h0);
      checkOutput("bp1.in_ready", {31'h0, in_ready_o}, 32'h0);
      applyStimulus(1'b1, 32'h00800413, 1'b1, 1'b0, 32'h0);
      checkOutput("bp2.in_ready", {31'h0, in_ready_o}, 32'h1);
      checkOut("bp2", 1'b1, 32'h00600313, 32'h84);
      applyStimulus(1'b1, 32'h00800413, 1'b0, 1'b0, 32'h0);
      checkOutput("bp3.count", 32'(dut.count), 32'd3);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOut("bp4", 1'b1, 32'h00700393, 32'h88);
      // Simultaneous push and free: count holds, order preserved
      applyStimulus(1'b1, 32'h00900493, 1'b1, 1'b0, 32'h0);
      checkOut("bp5", 1'b1, 32'h00800413, 32'h8C);
      checkOutput("bp5.count", 32'(dut.count), 32'd2);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOut("bp6", 1'b1, 32'h00900493, 32'h90);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOut("bp7", 1'b0, 32'h0, 32'h94);

      // PC wrap from the last halfword of the address space
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFE);
      applyStimulus(1'b1, 32'h00010000, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOut("wr0", 1'b1, 32'h00000001, 32'hFFFFFFFE);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOut("wr1", 1'b0, 32'h0, 32'h0);
      checkOutput("wr1.count", 32'(dut.count), 32'd0);
      checkOutput("wr1.offset", 32'(dut.offset), 32'd0);

      // Asynchronous reset mid-stream with two words buffered
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000040);
      applyStimulus(1'b1, 32'h00A00513, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h00B00593, 1'b0, 1'b0, 32'h0);
      in_valid_i = 1'b0;
      checkOutput("rs0.count", 32'(dut.count), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      checkOut("rs1", 1'b0, 32'h0, 32'h0);
      checkOutput("rs1.in_ready", {31'h0, in_ready_o}, 32'h1);
      checkOutput("rs1.count", 32'(dut.count), 32'd0);
      #2;
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/zeroriscy_fetch_realigner.md
Name: zeroriscy_fetch_realigner

Overview:
- Sits between the instruction-memory fetch port and the compressed decoder.
- Buffers 32-bit fetched words in a small FIFO and tracks the current PC at halfword granularity.
- Presents one PC-aligned instruction per handshake: a 16-bit compressed instruction, or a 32-bit one that may straddle two fetched words.
- On a flush it discards all buffered data and restarts at a new, possibly halfword-aligned, address.

Parameters:
- DEPTH, 3, number of 32-bit word entries in the FIFO; legal range is 2 or more.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear_i  input  1  flush strobe (branch, jump or exception).
- branch_addr_i  input  32  new PC, sampled when clear_i=1; bit 0 is ignored.
- in_valid_i  input  1  a fetched word is present.
- in_rdata_i  input  32  fetched word; it is the word containing the current fetch address.
- in_ready_o  output  1  FIFO can accept a word.
- out_valid_o  output  1  a complete instruction is available.
- out_ready_i  input  1  the decoder consumes the instruction.
- out_rdata_o  output  32  the aligned instruction.
- out_addr_o  output  32  PC of out_rdata_o.

Behaviour:
- Reset values:
  - FIFO count = 0, halfword offset = 0, pc = 32'h0.
  - Outputs: out_valid_o=0, out_rdata_o=0, out_addr_o=0, in_ready_o=1.
- State: word entries w0 (oldest) to w[DEPTH-1], a count, a 1-bit offset, and a 32-bit pc register.
- out_addr_o equals pc. The offset always equals pc[1].
- in_ready_o = (count < DEPTH), combinational from count only. It does not depend on a same-cycle pop.
- Push: when in_valid_i & in_ready_o & ~clear_i, the word is written at position count.
- There is no bypass. A word pushed at edge N can first appear on the outputs after edge N.
- Instruction extraction, combinational from stored state:
  - offset=0, w0[1:0]!=2'b11: compressed; rdata = {16'h0, w0[15:0]}; valid if count≥1.
  - offset=0, w0[1:0]==2'b11: rdata = w0; valid if count≥1.
  - offset=1, w0[17:16]!=2'b11: compressed; rdata = {16'h0, w0[31:16]}; valid if count≥1.
  - offset=1, w0[17:16]==2'b11: rdata = {w1[15:0], w0[31:16]}; valid only if count≥2.
  - When out_valid_o=0, out_rdata_o = 32'h0.
- Pop: occurs when out_valid_o & out_ready_i & ~clear_i.
  - pc += 2 if the instruction is compressed, else pc += 4.
  - offset0/compressed: offset becomes 1; no word is freed.
  - offset0/full: w0 is freed; offset stays 0.
  - offset1/compressed: w0 is freed; offset becomes 0.
  - offset1/full: w0 is freed; offset stays 1.
  - Freeing a word shifts the entries down by one.
- Simultaneous push and free in one cycle: count is unchanged, and the new word lands at position count-1.
- pc wraps modulo 2^32.
- Flush (clear_i=1) has priority over push and pop:
  - count becomes 0.
  - pc becomes {branch_addr_i[31:1], 1'b0}; offset becomes branch_addr_i[1].
  - An in_valid_i word in the same cycle is dropped.
  - The first word pushed after the flush is the word containing the new pc. With offset=1, its lower half is ignored.
- Reset asserted mid-operation returns every register to its reset value immediately, independent of clk.
- Illegal or unknown encodings are not checked here; the compressed decoder flags them.

Test Plan:
- Reset: assert rst mid-stream with count=2 -> out_valid_o=0, in_ready_o=1, out_addr_o=0 immediately.
- Aligned 32-bit stream: push 32'h00100093 then 32'h00200113, out_ready_i=1 -> outputs 32'h00100093 at addr 0, then 32'h00200113 at addr 4; count ends at 0.
- Compressed pair: push 32'h00050001 -> first output 32'h00000001 at addr 0, count stays 1. Second output 32'h00000005 at addr 2, after which count=0 and offset=0.
- Straddle after flush: clear_i with branch_addr_i=32'h102, then push 32'h0093ABCD.
  - Required: out_valid_o=0 and out_addr_o=32'h102.
  - Then push 32'h12340010. Required: out_rdata_o=32'h00100093 at addr 32'h102. On pop, pc=32'h106, offset=1, count=1.
- Flush while full: DEPTH=3, count=3, in_valid_i=1 and clear_i=1 with branch_addr_i=32'h80 -> next cycle count=0, out_valid_o=0, out_addr_o=32'h80, the incoming word is absent.
- Backpressure: fill to count=3 with out_ready_i=0 -> in_ready_o=0.
  - Then pop one full instruction while in_valid_i=1. Required: in_ready_o=1 in the following cycle, and the new word is accepted without loss or reordering.
